// File: rtl/instr_encoder_loader.sv
// Packs decoded MIPS instruction fields into 32-bit words and streams them into
// instruction memory at an auto-incrementing address. Optional checksum: INSTR_ENC_CHECKSUM_EN.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_last,
  input  logic [1:0]        i_class,
  input  logic [5:0]        i_opcode,
  input  logic [5:0]        i_funct,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_sa,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_done,
  output logic              o_err,
  output logic              o_overflow,
  output logic [31:0]       o_checksum,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t              r_state;
  logic                r_ready;
  logic                r_we;
  logic                r_last;
  logic                r_done;
  logic                r_err;
  logic                r_ovf;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_word;
  logic [ADDR_W:0]     r_count;
  logic [31:0]         w_word;
  logic                w_bad;
  logic                w_hs;

  // Handshake: a bundle transfers on a rising clock edge where i_valid and o_ready are both 1.
  assign w_hs = i_valid & r_ready;

  always_comb begin
    w_word = 32'd0;
    w_bad  = 1'b0;
    case (i_class)
      2'b00: w_word = {6'b0, i_rs, i_rt, i_rd, i_sa, i_funct};
      2'b01: begin
        w_word = {i_opcode, i_rs, i_rt, i_imm};
        w_bad  = (i_opcode == 6'd0);
      end
      2'b10: begin
        w_word = {i_opcode, i_target};
        w_bad  = !((i_opcode == 6'd2) || (i_opcode == 6'd3));
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_addr  <= '0;
      r_word  <= 32'd0;
      r_count <= '0;
    end else if (i_start) begin
      r_state <= S_LOAD;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: r_ready <= 1'b0;
        S_LOAD: begin
          if (w_hs) begin
            if (w_bad) begin
              r_err <= 1'b1;
              if (i_last) begin
                r_state <= S_DONE;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
              end
            end else if (r_count == DEPTH_C) begin
              r_ovf   <= 1'b1;
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_word  <= w_word;
              r_last  <= i_last;
              r_addr  <= r_count[ADDR_W-1:0];
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_we    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_we <= 1'b0;
          if (r_count != DEPTH_C) r_count <= r_count + ONE_C;
          if (r_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_LOAD;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] r_csum;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) r_csum <= 32'd0;
    else if (r_state == S_WRITE) r_csum <= r_csum ^ r_word;
  end
  assign o_checksum = r_csum;
`else
  assign o_checksum = 32'd0;
`endif

  // A reset or restart landing on the WRITE cycle must suppress that write immediately.
  assign o_mem_we    = r_we & ~i_rst & ~i_start;
  assign o_ready     = r_ready;
  assign o_mem_addr  = r_addr;
  assign o_mem_data  = r_word;
  assign o_count     = r_count;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_overflow  = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words.
- Streams each encoded word into instruction memory at an auto-incrementing word address.
- Used by the debug/load path to program the pipeline's instruction memory before run.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of writable words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse: clear counters and flags, begin a load session.
- i_valid  in  1  field bundle valid.
- o_ready  out  1  encoder ready to accept.
- i_last  in  1  bundle is the final instruction of the session.
- i_class  in  2  instruction class: 00 R, 01 I, 10 J, 11 reserved.
- i_opcode  in  6  opcode for I and J classes.
- i_funct  in  6  function code for R class.
- i_rs, i_rt, i_rd, i_sa  in  5 each  register and shift fields.
- i_imm  in  16  immediate or branch offset.
- i_target  in  26  jump target.
- o_mem_we  out  1  instruction-memory write enable.
- o_mem_addr  out  ADDR_W  word address.
- o_mem_data  out  32  encoded instruction.
- o_count  out  ADDR_W+1  words written this session.
- o_done  out  1  one-cycle pulse when the session ends.
- o_err  out  1  sticky: an invalid bundle was rejected.
- o_overflow  out  1  sticky: a bundle arrived with memory full.
- o_checksum  out  32  see Optional Feature.

Behaviour:
- Reset: state IDLE. All outputs are 0: o_ready, o_mem_we, o_mem_addr, o_mem_data, o_count, o_done, o_err, o_overflow, o_checksum.
- Encoding:
  - R: {6'b0, rs, rt, rd, sa, funct}; i_opcode is ignored.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, target}.
- Invalid bundles: class 11; I with opcode 0; J with opcode other than 2 or 3.
- States:
  - IDLE: o_ready=0. i_start → LOAD.
  - LOAD: o_ready=1.
    - Handshake is i_valid & o_ready.
    - Invalid bundle: set o_err, no write. If i_last, go DONE; otherwise stay in LOAD.
    - Valid bundle with o_count==DEPTH: set o_overflow, no write, go DONE.
    - Otherwise: register the word and i_last, go WRITE.
  - WRITE: o_ready=0, o_mem_we=1, o_mem_addr=o_count[ADDR_W-1:0], o_mem_data=word.
    - o_count increments at the end of the cycle.
    - Next state is DONE if the registered last flag is set, else LOAD.
  - DONE: o_done=1 for exactly one cycle, then IDLE. o_count, o_err, o_overflow and o_mem_data hold.
- Timing: write latency is 1 cycle after handshake. Throughput is 1 word per 2 cycles.
- i_start in any state other than IDLE:
  - Restarts: o_count=0, o_err=0, o_overflow=0, checksum=0, next state LOAD.
  - Any pending write is discarded (o_mem_we stays 0 that cycle).
  - A handshake in the same cycle is ignored.
- Priority: i_rst > i_start > handshake.
- o_mem_we is never high outside WRITE.
- o_count saturates at DEPTH; the address never wraps.
- i_valid without i_start in IDLE is ignored (o_ready=0).

Optional Feature:
- Macro: INSTR_ENC_CHECKSUM_EN.
- Defined: o_checksum is a running XOR of every word written. It updates in the WRITE cycle, clears on reset and i_start, and holds in DONE/IDLE.
- Undefined: o_checksum is constant 0 and no checksum register exists.

Test Plan:
- R encode: i_start; bundle class 00, rs=1, rt=2, rd=3, sa=0, funct=0x21, i_last=0 → next cycle o_mem_we=1, o_mem_addr=0, o_mem_data=0x00221821; then o_count=1 and state returns to LOAD.
- I then J encode:
  - class 01, opcode 0x09, rs=1, rt=2, imm=0x0005 → 0x24220005 at addr 1.
  - Then class 10, opcode 0x03, target 0x0000040 with i_last=1 → 0x0C000040 at addr 2.
  - o_done pulses 1 cycle later, o_count=3.
  - With INSTR_ENC_CHECKSUM_EN defined: o_checksum=0x00221821^0x24220005^0x0C000040.
- Invalid bundle: class 01, opcode 0 → o_err=1, no o_mem_we, o_count unchanged, o_ready stays 1; a following valid bundle still writes.
- Overflow (DEPTH=4): 5 valid bundles with i_last=0 → 4 writes to addr 0–3; 5th sets o_overflow=1, no write, o_done pulses, o_count=4.
- Reset/restart mid-operation:
  - i_rst asserted in WRITE → o_mem_we=0 that cycle, all outputs 0, IDLE.
  - Separately, i_start in WRITE → no write, o_count=0, LOAD with o_ready=1 next cycle.
